// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared types and register order for the dump sequencer.
// Slot order walks $s0-$s7, $t0-$t7, then $t8-$t9.
package reg_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SEND,
        RUN,
        DONE
    } state_t;

    localparam int NUM_REGS = 18;
    localparam logic [4:0] LAST_SLOT = 5'(NUM_REGS - 1);

    // Slots 0-7 -> 16-23, 8-15 -> 8-15, 16-17 -> 24-25.
    function automatic logic [4:0] slot_to_reg(input logic [4:0] slot);
        logic [4:0] r;
        if (slot < 5'd8) begin
            r = slot + 5'd16;
        end else if (slot < 5'd16) begin
            r = slot;
        end else begin
            r = slot + 5'd8;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer: walks the processor register file through
// SwitchSelector, streams each value out, then optionally steps the core.
module reg_dump_sequencer
    import reg_dump_pkg::*;
#(
    parameter int SETTLE_CYCLES    = 2,
    parameter int RUN_PULSE_CYCLES = 16
) (
    input  logic        clkFast,
    input  logic        reset,
    input  logic        start,
    input  logic        step_en,
    input  logic [31:0] rd_data,
    output logic [4:0]  sel,
    output logic        run,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [31:0] dump_data,
    output logic [4:0]  dump_idx,
    output logic        dump_last,
    output logic        busy,
    output logic        done,
    output logic [15:0] step_count
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] RUN_LAST    = 16'(RUN_PULSE_CYCLES - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [4:0]  slot, slot_n;
    logic        step_q, step_q_n;
    logic [4:0]  sel_n;
    logic        run_n;
    logic        dump_valid_n;
    logic [31:0] dump_data_n;
    logic [4:0]  dump_idx_n;
    logic        dump_last_n;
    logic        busy_n;
    logic        done_n;
    logic [15:0] step_count_n;

    // State register.
    always_ff @(posedge clkFast or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Counters, capture register and registered outputs.
    always_ff @(posedge clkFast or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            slot       <= '0;
            step_q     <= 1'b0;
            sel        <= '0;
            run        <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            dump_idx   <= '0;
            dump_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_count <= '0;
        end else begin
            cnt        <= cnt_n;
            slot       <= slot_n;
            step_q     <= step_q_n;
            sel        <= sel_n;
            run        <= run_n;
            dump_valid <= dump_valid_n;
            dump_data  <= dump_data_n;
            dump_idx   <= dump_idx_n;
            dump_last  <= dump_last_n;
            busy       <= busy_n;
            done       <= done_n;
            step_count <= step_count_n;
        end
    end

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        slot_n       = slot;
        step_q_n     = step_q;
        sel_n        = sel;
        run_n        = run;
        dump_valid_n = dump_valid;
        dump_data_n  = dump_data;
        dump_idx_n   = dump_idx;
        dump_last_n  = dump_last;
        busy_n       = busy;
        done_n       = 1'b0;
        step_count_n = step_count;
        unique case (state)
            IDLE: begin
                sel_n = '0;
                run_n = 1'b0;
                if (start) begin
                    step_q_n = step_en;
                    slot_n   = '0;
                    sel_n    = slot_to_reg(5'd0);
                    busy_n   = 1'b1;
                    cnt_n    = '0;
                    state_n  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    dump_data_n  = rd_data;
                    dump_idx_n   = sel;
                    dump_last_n  = (slot == LAST_SLOT);
                    dump_valid_n = 1'b1;
                    state_n      = SEND;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            SEND: begin
                if (dump_ready) begin
                    dump_valid_n = 1'b0;
                    cnt_n        = '0;
                    if (slot != LAST_SLOT) begin
                        slot_n  = slot + 5'd1;
                        sel_n   = slot_to_reg(slot + 5'd1);
                        state_n = SETTLE;
                    end else if (step_q) begin
                        run_n   = 1'b1;
                        state_n = RUN;
                    end else begin
                        done_n  = 1'b1;
                        sel_n   = '0;
                        state_n = DONE;
                    end
                end
            end
            RUN: begin
                if (cnt == RUN_LAST) begin
                    run_n        = 1'b0;
                    step_count_n = step_count + 16'd1;
                    done_n       = 1'b1;
                    sel_n        = '0;
                    state_n      = DONE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// tb_reg_dump_sequencer: scoreboard bench with a registered register-file
// model; expected beats and per-sequence results are queued at start time.
module tb_reg_dump_sequencer;

    localparam int S    = 2;
    localparam int R    = 16;
    localparam int NREG = 18;

    logic        clkFast = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        step_en = 1'b0;
    logic        dump_ready = 1'b0;
    logic [31:0] rd_data = '0;
    logic [4:0]  sel;
    logic        run;
    logic        dump_valid;
    logic [31:0] dump_data;
    logic [4:0]  dump_idx;
    logic        dump_last;
    logic        busy;
    logic        done;
    logic [15:0] step_count;

    reg_dump_sequencer #(
        .SETTLE_CYCLES(S),
        .RUN_PULSE_CYCLES(R)
    ) dut (
        .clkFast(clkFast),
        .reset(reset),
        .start(start),
        .step_en(step_en),
        .rd_data(rd_data),
        .sel(sel),
        .run(run),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_data(dump_data),
        .dump_idx(dump_idx),
        .dump_last(dump_last),
        .busy(busy),
        .done(done),
        .step_count(step_count)
    );

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        bit          step;
        int          k;
        logic [15:0] cnt;
    } seq_t;

    int          order[NREG] = '{16, 17, 18, 19, 20, 21, 22, 23,
                                 8, 9, 10, 11, 12, 13, 14, 15, 24, 25};
    beat_t       beat_q[$];
    seq_t        seq_q[$];
    logic [31:0] base = 32'hA000_0000;
    logic [15:0] exp_steps = '0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          ready_rand = 1'b0;
    bit          ready_force = 1'b1;

    always #5 clkFast = ~clkFast;

    // Processor model: register file output settles one edge after sel.
    always @(posedge clkFast) begin
        cyc     <= cyc + 1;
        rd_data <= base + {27'd0, sel};
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_seq(input bit st, input int k);
        beat_t b;
        seq_t  q;
        for (int i = 0; i < NREG; i++) begin
            b.idx  = 5'(order[i]);
            b.data = base + 32'(order[i]);
            b.last = (i == NREG - 1);
            beat_q.push_back(b);
        end
        if (st) exp_steps = exp_steps + 16'd1;
        q.step = st;
        q.k    = k;
        q.cnt  = exp_steps;
        seq_q.push_back(q);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clkFast);
            #1;
            n++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_seq(input bit st, input bit timed);
        int k;
        wait_idle();
        @(posedge clkFast);
        #1;
        k = timed ? cyc + 1 : -1;
        push_seq(st, k);
        start   = 1'b1;
        step_en = st;
        @(posedge clkFast);
        #1;
        start   = 1'b0;
        step_en = 1'($urandom);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_sel", 32'(sel), 32'd16);
        wait_idle();
    endtask

    task automatic check_reset_vals();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_run", 32'(run), 32'd0);
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_data", dump_data, 32'd0);
        check("rst_idx", 32'(dump_idx), 32'd0);
        check("rst_last", 32'(dump_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_steps", 32'(step_count), 32'd0);
    endtask

    // Ready driver: tied value or random stalls.
    initial begin
        forever begin
            @(posedge clkFast);
            #1;
            dump_ready = ready_rand ? ($urandom_range(0, 2) != 0) : ready_force;
        end
    end

    // Monitor: pops expected beats on handshakes and sequence results on done.
    initial begin
        beat_t b;
        seq_t  q;
        int    run_cyc = 0;
        int    beats = 0;
        bit    prev_stall = 1'b0;
        bit    prev_done = 1'b0;
        beat_t held;
        forever begin
            @(negedge clkFast);
            if (!reset) begin
                run_cyc    = 0;
                beats      = 0;
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", 32'(dump_valid), 32'd1);
                    check("stall_data", dump_data, held.data);
                    check("stall_idx", 32'(dump_idx), 32'(held.idx));
                    check("stall_last", 32'(dump_last), 32'(held.last));
                end
                if (dump_valid && dump_ready) begin
                    if (beat_q.size() == 0) begin
                        check("beat_extra", 32'(dump_idx), 32'h1F);
                    end else begin
                        b = beat_q.pop_front();
                        check("beat_idx", 32'(dump_idx), 32'(b.idx));
                        check("beat_data", dump_data, b.data);
                        check("beat_last", 32'(dump_last), 32'(b.last));
                    end
                    beats++;
                end
                prev_stall = dump_valid && !dump_ready;
                held.data  = dump_data;
                held.idx   = dump_idx;
                held.last  = dump_last;
                if (run) run_cyc++;
                if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
                if (done) begin
                    check("done_width", 32'(prev_done), 32'd0);
                    if (seq_q.size() == 0) begin
                        check("done_extra", 32'(done), 32'd0);
                    end else begin
                        q = seq_q.pop_front();
                        check("run_cycles", 32'(run_cyc), q.step ? R : 0);
                        check("step_count", 32'(step_count), 32'(q.cnt));
                        check("beat_count", 32'(beats), NREG);
                        if (q.k >= 0) begin
                            check("done_latency", 32'(cyc - q.k),
                                  32'(NREG * (S + 1) + (q.step ? R : 0)));
                        end
                    end
                    run_cyc = 0;
                    beats   = 0;
                end
                prev_done = done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int n;
        repeat (2) @(posedge clkFast);
        #1;
        check_reset_vals();
        @(negedge clkFast);
        reset = 1'b1;

        run_seq(1'b1, 1'b1);
        run_seq(1'b0, 1'b1);

        // Reset while a beat is parked in SEND.
        ready_force = 1'b0;
        wait_idle();
        @(posedge clkFast);
        #1;
        push_seq(1'b1, -1);
        start   = 1'b1;
        step_en = 1'b1;
        @(posedge clkFast);
        #1;
        start = 1'b0;
        n = 0;
        while (!dump_valid && n < 100) begin
            @(posedge clkFast);
            #1;
            n++;
        end
        check("send_reached", 32'(dump_valid), 32'd1);
        repeat (3) @(posedge clkFast);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals();
        beat_q.delete();
        seq_q.delete();
        exp_steps   = '0;
        ready_force = 1'b1;
        @(negedge clkFast);
        @(negedge clkFast);
        reset = 1'b1;
        run_seq(1'b1, 1'b1);

        // Random stalls and random register contents.
        ready_rand = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_idle();
            base = $urandom;
            run_seq(1'($urandom), 1'b0);
        end

        // Start held high: one sequence per IDLE visit, step_en latched.
        wait_idle();
        base = $urandom;
        @(posedge clkFast);
        #1;
        push_seq(1'b1, -1);
        push_seq(1'b0, -1);
        start   = 1'b1;
        step_en = 1'b1;
        @(posedge clkFast);
        #1;
        step_en = 1'b0;
        n = 0;
        while (busy && n < 5000) begin
            @(posedge clkFast);
            #1;
            n++;
        end
        check("held_idle_gap", 32'(busy), 32'd0);
        @(posedge clkFast);
        #1;
        check("held_restart", 32'(busy), 32'd1);
        start = 1'b0;
        wait_idle();
        repeat (5) @(posedge clkFast);
        #1;
        check("held_no_third", 32'(busy), 32'd0);

        // Step counter wrap.
        ready_rand = 1'b0;
        wait_idle();
        @(negedge clkFast);
        force dut.step_count = 16'hFFFF;
        @(posedge clkFast);
        @(negedge clkFast);
        release dut.step_count;
        exp_steps = 16'hFFFF;
        @(negedge clkFast);
        check("preload", 32'(step_count), 32'h0000_FFFF);
        run_seq(1'b1, 1'b1);
        check("wrap", 32'(step_count), 32'd0);

        repeat (3) @(posedge clkFast);
        #1;
        check("beats_left", 32'(beat_q.size()), 32'd0);
        check("seqs_left", 32'(seq_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_dump_sequencer.md
# reg_dump_sequencer

Hardware debug sequencer that sits directly in front of `single_cycle_processor` and drives its `SwitchSelector` and `switchRun` inputs. It consumes `reg_read_data_1`. On each `start` request it walks the 18 architectural registers ($s0–$s7, $t0–$t9) and streams each value out over a valid/ready port. It then optionally pulses `switchRun` to advance the processor one step. It replaces bench-driven register polling, so register dumps can feed a UART or display on the board.

## Interface
- `SETTLE_CYCLES`, default 2: cycles `sel` is held before `rd_data` is sampled; legal range ≥1.
- `RUN_PULSE_CYCLES`, default 16: cycles `run` is held high per step; legal range ≥1.
- `clkFast` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request one dump (+ optional step); sampled only in IDLE.
- `step_en` in 1: sampled together with `start`; 1 means pulse `run` after the dump.
- `rd_data` in 32: from processor `reg_read_data_1`.
- `sel` out 5: to processor `SwitchSelector`.
- `run` out 1: to processor `switchRun`.
- `dump_valid` out 1: `dump_data`/`dump_idx`/`dump_last` are valid.
- `dump_ready` in 1: downstream accepts the beat.
- `dump_data` out 32: captured register value.
- `dump_idx` out 5: register number of the beat.
- `dump_last` out 1: high on the 18th beat.
- `busy` out 1: high from start acceptance until return to IDLE.
- `done` out 1: one-cycle pulse at sequence completion.
- `step_count` out 16: completed run pulses, wraps 0xFFFF→0x0000.

## Operation
- Register order, fixed: slots 0–17 map to 16,17,18,19,20,21,22,23,8,9,10,11,12,13,14,15,24,25.
- FSM states: IDLE, SETTLE, SEND, RUN, DONE.
- IDLE: if `start`=1, latch `step_en`, set slot=0, `sel`=16, `busy`=1, go to SETTLE. Otherwise `sel`=0 and `run`=0.
- SETTLE: count SETTLE_CYCLES cycles with `sel` stable. On the final cycle, register `rd_data`→`dump_data`, `sel`→`dump_idx`, slot==17→`dump_last`, set `dump_valid`=1, go to SEND.
- SEND: hold all dump outputs stable while `dump_ready`=0. On `dump_valid && dump_ready`, clear `dump_valid`.
  - If slot<17: slot+1, `sel`=next entry, go to SETTLE.
  - Else if the latched step_en=1, go to RUN; otherwise go to DONE.
- RUN: `run`=1 for exactly RUN_PULSE_CYCLES cycles; `sel` holds 25. On exit, `run`=0, `step_count`+1, go to DONE.
- DONE: `done`=1 for one cycle, `sel`=0, then go to IDLE with `busy`=0.
- `start` while busy is ignored, not queued. `step_en` changes after acceptance have no effect.
- Reset values (any state, asserted asynchronously): state IDLE, `sel`=0, `run`=0, `dump_valid`=0, `dump_data`=0, `dump_idx`=0, `dump_last`=0, `busy`=0, `done`=0, `step_count`=0. A reset mid-RUN drops `run` immediately and does not count the step.

## Timing
- `start` high at edge k: `busy`=1, `sel`=16 after edge k.
- First `dump_valid` rises after edge k+SETTLE_CYCLES.
- With `dump_ready` tied 1, each register costs SETTLE_CYCLES+1 cycles, so the 18th handshake lands at edge k+18·(SETTLE_CYCLES+1).
- `run` rises on the next edge and stays high RUN_PULSE_CYCLES cycles.
- `done` is high for the cycle after `run` falls; `busy` falls one edge later.
- Defaults, ready=1, step_en=1: `run` is high over edges k+54..k+70, `done` at k+70, `busy` low after k+71.
- Backpressure adds one cycle per cycle of `dump_ready`=0. No beat is ever dropped or duplicated.
- `dump_valid` never deasserts without a handshake.

## Structure
- Package `reg_dump_pkg` holds:
  - the state enum;
  - the constant NUM_REGS=18;
  - a function mapping slot (0–17) to register number (the order table).
- No sub-module. Single module with an FSM, settle/run counter, 5-bit slot counter, capture register and 16-bit step counter.

## Test plan
- Reset low mid-SEND: all outputs read their reset values immediately. After release, `start` with step_en=1 dumps and steps normally.
- Defaults, ready=1, step_en=1, processor model returns value = 0xA000_0000+sel: 18 beats with idx 16..23, 8..15, 24, 25 and data matching; `dump_last` on beat 18 only; `run` high exactly 16 cycles; `step_count`=1; `done` one cycle.
- step_en=0: 18 beats, `run` never asserts, `step_count` unchanged, `done` pulses.
- Random `dump_ready` stalls: beat contents stay stable while stalled; all 18 beats arrive in order exactly once.
- `start` held high through a whole sequence: exactly one sequence per IDLE visit; a second sequence begins only after `busy` falls.
- Preload `step_count`=0xFFFF via 65535 stepped runs (or force): the next step wraps it to 0x0000.
